can_bit_timing: RTL and testbench

//  CAN bit-timing unit, the stage directly downstream of the quantum divider.

---
 rtl/can_timing_pkg.sv | 32 +++
 rtl/can_rx_sync.sv | 36 +++
 rtl/can_bit_timing.sv | 152 +++++++++++++++
 tb/tb_can_bit_timing.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/can_timing_pkg.sv
// Shared definitions for the CAN bit-timing unit: segment state encoding,
// counter width, segment length limits and a parameter range check.
package can_timing_pkg;

  // Width of the quantum counters; the longest segment is
  // PROP_SEG_MAX + PHASE_SEG1_MAX + SJW_MAX = 20 tq, so 5 bits never wrap.
  localparam int CNT_W = 5;

  localparam int PROP_SEG_MAX   = 8;
  localparam int PHASE_SEG1_MAX = 8;
  localparam int PHASE_SEG2_MIN = 2;
  localparam int PHASE_SEG2_MAX = 8;
  localparam int SJW_MAX        = 4;

  // Bit segment the timing FSM is currently counting through.
  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TSEG1 = 2'd1,
    ST_TSEG2 = 2'd2
  } seg_state_t;

  // True when a parameter set lies inside the supported timing ranges.
  function automatic bit params_ok(input int prop_seg, input int phase_seg1,
                                   input int phase_seg2, input int sjw);
    return (prop_seg   >= 1)              && (prop_seg   <= PROP_SEG_MAX)   &&
           (phase_seg1 >= 1)              && (phase_seg1 <= PHASE_SEG1_MAX) &&
           (phase_seg2 >= PHASE_SEG2_MIN) && (phase_seg2 <= PHASE_SEG2_MAX) &&
           (sjw        >= 1)              && (sjw        <= SJW_MAX)        &&
           (sjw <= phase_seg2);
  endfunction

endpackage

// File: rtl/can_rx_sync.sv
// Brings the asynchronous CAN RX pin into the clk50Mhz domain and flags a
// recessive-to-dominant transition, evaluated only on time-quantum ticks.
module can_rx_sync (
  input  logic clk50Mhz,
  input  logic reset,
  input  logic tq_tick,
  input  logic rx,
  output logic rx_s,
  output logic rx_edge
);

  logic rx_meta;
  logic rx_prev;

  // Two-flop synchroniser every clock; previous bus value tracked per quantum.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // synchroniser into a single stage.
  always_ff @(posedge clk50Mhz or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      if (tq_tick) begin
        rx_prev <= rx_s;
      end
    end
  end

  // Falling edge as seen at quantum granularity: recessive last tick, dominant now.
  assign rx_edge = tq_tick && rx_prev && !rx_s;

endmodule

// File: rtl/can_bit_timing.sv
// CAN bit-timing unit: splits each bit into SYNC/TSEG1/TSEG2 on time-quantum
// ticks, strobes the sample point and the start of each bit, and realigns the
// bit to the bus through hard sync and SJW-limited resynchronisation.
module can_bit_timing
  import can_timing_pkg::*;
#(
  parameter int PROP_SEG   = 2,
  parameter int PHASE_SEG1 = 3,
  parameter int PHASE_SEG2 = 3,
  parameter int SJW        = 1
) (
  input  logic clk50Mhz,
  input  logic reset,
  input  logic tq_tick,
  input  logic rx,
  input  logic hard_sync_en,
  output logic sample_pulse,
  output logic sampled_bit,
  output logic bit_start
);

  if (!params_ok(PROP_SEG, PHASE_SEG1, PHASE_SEG2, SJW)) begin : g_bad_params
    $error("can_bit_timing: segment parameters out of range");
  end

  localparam logic [CNT_W-1:0] L1_C  = CNT_W'(PROP_SEG + PHASE_SEG1);
  localparam logic [CNT_W-1:0] PS2_C = CNT_W'(PHASE_SEG2);
  localparam logic [CNT_W-1:0] SJW_C = CNT_W'(SJW);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  seg_state_t       state;
  logic [CNT_W-1:0] cnt;          // 1-based quantum index inside the current segment
  logic [CNT_W-1:0] ext;          // TSEG1 lengthening granted this bit
  logic [CNT_W-1:0] shr;          // TSEG2 shortening granted this bit
  logic             resync_done;  // one resync per bit

  logic             rx_s;
  logic             rx_edge;

  logic             hard_sync;
  logic             resync_ok;
  logic [CNT_W-1:0] k_ext;
  logic [CNT_W-1:0] e_tseg2;
  logic [CNT_W-1:0] k_shr;
  logic [CNT_W-1:0] len1;
  logic [CNT_W-1:0] len2;
  logic             late_edge;

  can_rx_sync u_rx_sync (
    .clk50Mhz (clk50Mhz),
    .reset    (reset),
    .tq_tick  (tq_tick),
    .rx       (rx),
    .rx_s     (rx_s),
    .rx_edge  (rx_edge)
  );

  // Hard sync wins over resync; resync only follows a recessive sample.
  assign hard_sync = rx_edge && hard_sync_en;
  assign resync_ok = rx_edge && !hard_sync_en && sampled_bit && !resync_done;

  // Phase error of an edge: lateness in TSEG1, earliness in TSEG2, capped at SJW.
  assign k_ext     = (cnt < SJW_C) ? cnt : SJW_C;
  assign e_tseg2   = PS2_C - cnt + ONE;
  assign k_shr     = (e_tseg2 < SJW_C) ? e_tseg2 : SJW_C;

  // Effective segment lengths including a correction made on this very tick.
  assign len1      = L1_C + (resync_ok ? k_ext : ext);
  assign len2      = PS2_C - (resync_ok ? k_shr : shr);

  // An edge within SJW of the nominal SYNC is absorbed: its quantum becomes SYNC.
  assign late_edge = resync_ok && (e_tseg2 <= SJW_C);

  // Segment FSM: one step per quantum tick, strobes registered for one clock.
  // After reset cnt=0 marks a SYNC quantum not yet announced, so the first tick
  // out of reset also raises bit_start; later SYNC entries announce themselves.
  always_ff @(posedge clk50Mhz or posedge reset) begin
    if (reset) begin
      state        <= ST_SYNC;
      cnt          <= '0;
      ext          <= '0;
      shr          <= '0;
      resync_done  <= 1'b0;
      sampled_bit  <= 1'b1;
      sample_pulse <= 1'b0;
      bit_start    <= 1'b0;
    end else begin
      sample_pulse <= 1'b0;
      bit_start    <= 1'b0;
      if (tq_tick) begin
        if (hard_sync) begin
          state       <= ST_TSEG1;
          cnt         <= ONE;
          ext         <= '0;
          shr         <= '0;
          resync_done <= 1'b0;
          bit_start   <= 1'b1;
        end else begin
          case (state)
            ST_SYNC: begin
              bit_start <= (cnt == '0);
              state     <= ST_TSEG1;
              cnt       <= ONE;
            end
            ST_TSEG1: begin
              if (resync_ok) begin
                ext         <= k_ext;
                resync_done <= 1'b1;
              end
              if (cnt == len1) begin
                sample_pulse <= 1'b1;
                sampled_bit  <= rx_s;
                state        <= ST_TSEG2;
                cnt          <= ONE;
              end else begin
                cnt <= cnt + ONE;
              end
            end
            ST_TSEG2: begin
              if (late_edge) begin
                state       <= ST_TSEG1;
                cnt         <= ONE;
                ext         <= '0;
                shr         <= '0;
                resync_done <= 1'b0;
                bit_start   <= 1'b1;
              end else if (cnt == len2) begin
                state       <= ST_SYNC;
                cnt         <= ONE;
                ext         <= '0;
                shr         <= '0;
                resync_done <= 1'b0;
                bit_start   <= 1'b1;
              end else begin
                if (resync_ok) begin
                  shr         <= k_shr;
                  resync_done <= 1'b1;
                end
                cnt <= cnt + ONE;
              end
            end
            default: begin
              state <= ST_SYNC;
              cnt   <= ONE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_can_bit_timing.sv
// Self-checking bench for can_bit_timing at default parameters with one
// quantum every 4 clocks. Expected strobes (kind, quantum index, sampled value)
// are queued per scenario and matched against what the DUT emits.
module tb_can_bit_timing;

  logic clk50Mhz = 1'b0;
  logic reset;
  logic tq_tick;
  logic rx;
  logic hard_sync_en;
  logic sample_pulse;
  logic sampled_bit;
  logic bit_start;

  typedef struct packed {
    logic        kind;   // 0 = bit_start, 1 = sample_pulse
    logic [15:0] tq;     // quantum index of the tick that causes it
    logic        bitv;   // expected sampled_bit for sample events
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] tq_n = '0;
  int          n_checks = 0;
  int          n_fail   = 0;

  can_bit_timing dut (
    .clk50Mhz     (clk50Mhz),
    .reset        (reset),
    .tq_tick      (tq_tick),
    .rx           (rx),
    .hard_sync_en (hard_sync_en),
    .sample_pulse (sample_pulse),
    .sampled_bit  (sampled_bit),
    .bit_start    (bit_start)
  );

  always #10 clk50Mhz = ~clk50Mhz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d (tq=%0d)", tag, obs, exp_v, tq_n);
    end
  endtask

  task automatic expect_ev(input logic kind, input int tq, input logic bitv);
    ev_t e;
    e.kind = kind;
    e.tq   = 16'(tq);
    e.bitv = bitv;
    exp_q.push_back(e);
  endtask

  // One quantum: rx/hard_sync_en set right after the previous tick have three
  // clocks to cross the synchroniser before the next tq_tick is consumed.
  task automatic step(input logic r, input logic hs);
    rx           = r;
    hard_sync_en = hs;
    tq_tick      = 1'b0;
    repeat (3) @(negedge clk50Mhz);
    tq_tick = 1'b1;
    tq_n    = tq_n + 16'd1;
    @(negedge clk50Mhz);
    tq_tick = 1'b0;
  endtask

  task automatic drive(input int n, input logic r, input logic hs);
    for (int i = 0; i < n; i++) step(r, hs);
  endtask

  task automatic got_event(input logic kind, input logic bitv);
    ev_t e;
    if (exp_q.size() == 0) begin
      check(kind ? "unexpected_sample_pulse" : "unexpected_bit_start", 32'(1), 32'(0));
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      check(kind ? "sample_tq" : "bit_start_tq", 32'(tq_n), 32'(e.tq));
      if (kind && e.kind) check("sampled_bit", 32'(bitv), 32'(e.bitv));
    end
  endtask

  // Monitor: every strobe seen between clock edges is one scoreboard event.
  initial begin
    forever begin
      @(negedge clk50Mhz);
      if (!reset) begin
        if (bit_start)    got_event(1'b0, 1'b0);
        if (sample_pulse) got_event(1'b1, sampled_bit);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at tq=%0d", tq_n);
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    tq_tick      = 1'b0;
    rx           = 1'b1;
    hard_sync_en = 1'b0;
    repeat (3) @(negedge clk50Mhz);
    check("reset_sample_pulse", 32'(sample_pulse), 32'(0));
    check("reset_bit_start",    32'(bit_start),    32'(0));
    check("reset_sampled_bit",  32'(sampled_bit),  32'(1));
    reset = 1'b0;

    // Idle recessive bus: 9-tq bits, sample 6 tq after each bit_start.
    expect_ev(1'b0, 1, 1'b0);
    expect_ev(1'b1, 6, 1'b1);  expect_ev(1'b0, 9, 1'b0);
    expect_ev(1'b1, 15, 1'b1); expect_ev(1'b0, 18, 1'b0);
    expect_ev(1'b1, 24, 1'b1);
    drive(25, 1'b1, 1'b0);

    // Hard sync at TSEG2 quantum 2: bit restarts there, sample 5 tq later.
    expect_ev(1'b0, 26, 1'b0); expect_ev(1'b1, 31, 1'b0); expect_ev(1'b0, 34, 1'b0);
    step(1'b0, 1'b1);
    drive(8, 1'b0, 1'b0);

    // Edge at TSEG1 quantum 3 lengthens that bit to 10 tq; a second edge in
    // TSEG2 of the same bit is ignored.
    expect_ev(1'b1, 40, 1'b1); expect_ev(1'b0, 43, 1'b0);
    expect_ev(1'b1, 50, 1'b1); expect_ev(1'b0, 53, 1'b0);
    drive(12, 1'b1, 1'b0);
    step(1'b0, 1'b0);
    drive(4, 1'b1, 1'b0);
    step(1'b0, 1'b0);

    // TSEG2 quantum 2 edge shortens the bit to 8 tq; quantum 3 edge becomes
    // the new SYNC; an edge inside SYNC changes nothing.
    expect_ev(1'b1, 59, 1'b1); expect_ev(1'b0, 61, 1'b0);
    expect_ev(1'b1, 67, 1'b1); expect_ev(1'b0, 70, 1'b0);
    expect_ev(1'b1, 75, 1'b1); expect_ev(1'b0, 78, 1'b0);
    expect_ev(1'b1, 84, 1'b1); expect_ev(1'b0, 87, 1'b0);
    drive(8, 1'b1, 1'b0);
    step(1'b0, 1'b0);
    drive(8, 1'b1, 1'b0);
    step(1'b0, 1'b0);
    drive(8, 1'b1, 1'b0);
    step(1'b0, 1'b0);
    drive(11, 1'b1, 1'b0);

    // Quantum ticks stop for 100 clocks with rx bouncing: nothing may move;
    // the falling edge is only seen at the next tick (TSEG1 quantum 3).
    expect_ev(1'b1, 94, 1'b0); expect_ev(1'b0, 97, 1'b0);
    tq_tick = 1'b0;
    for (int i = 0; i < 97; i++) begin
      @(negedge clk50Mhz);
      rx = 1'($urandom_range(0, 1));
    end
    @(negedge clk50Mhz);
    rx = 1'b0;
    @(negedge clk50Mhz);
    check("frozen_sampled_bit", 32'(sampled_bit), 32'(1));
    drive(10, 1'b0, 1'b0);
    check("pending_before_reset", 32'(exp_q.size()), 32'(0));
    check("sampled_bit_before_reset", 32'(sampled_bit), 32'(0));

    // Asynchronous reset mid-TSEG1 for two clocks.
    @(negedge clk50Mhz);
    #3 reset = 1'b1;
    #1;
    check("midbit_reset_sampled_bit",  32'(sampled_bit),  32'(1));
    check("midbit_reset_sample_pulse", 32'(sample_pulse), 32'(0));
    check("midbit_reset_bit_start",    32'(bit_start),    32'(0));
    repeat (2) @(posedge clk50Mhz);
    @(negedge clk50Mhz);
    reset = 1'b0;
    tq_n  = '0;
    expect_ev(1'b0, 1, 1'b0); expect_ev(1'b1, 6, 1'b1); expect_ev(1'b0, 9, 1'b0);
    drive(10, 1'b1, 1'b0);
    repeat (2) @(negedge clk50Mhz);
    check("pending_at_end", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
